// File: rtl/ysyx_24090018_wbu_if.sv
// Handshake and write-port bundle between IDU/EXU/LSU and the writeback unit.
// The writeback unit connects through the slave modport; its environment uses the master modport.
interface ysyx_24090018_wbu_if #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 32
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic                      issue_valid_i;
    logic [REG_ADDR_WIDTH-1:0] issue_rd_i;
    logic [REG_ADDR_WIDTH-1:0] issue_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] issue_rs2_i;
    logic                      hazard_o;

    logic                      exu_valid_i;
    logic [REG_ADDR_WIDTH-1:0] exu_rd_i;
    logic [DATA_WIDTH-1:0]     exu_data_i;
    logic                      exu_ready_o;

    logic                      lsu_valid_i;
    logic [REG_ADDR_WIDTH-1:0] lsu_rd_i;
    logic [DATA_WIDTH-1:0]     lsu_data_i;
    logic                      lsu_ready_o;

    logic                      rf_wen_o;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0]     rf_wdata_o;
    logic [NREG-1:0]           busy_o;
    logic                      sb_err_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  exu_valid_i, exu_rd_i, exu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output hazard_o, exu_ready_o, lsu_ready_o,
        output rf_wen_o, rf_waddr_o, rf_wdata_o, busy_o, sb_err_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        output exu_valid_i, exu_rd_i, exu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  hazard_o, exu_ready_o, lsu_ready_o,
        input  rf_wen_o, rf_waddr_o, rf_wdata_o, busy_o, sb_err_o
    );
endinterface

// File: rtl/ysyx_24090018_wbu.sv
// Writeback unit: round-robin EXU/LSU arbitration, registered RF write port,
// and a busy-bit scoreboard that stalls decode on RAW/WAW hazards.
//
// state        | meaning
// ARB_LAST_EXU | EXU won the last conflict (or none yet); LSU wins the next one
// ARB_LAST_LSU | LSU won the last conflict; EXU wins the next one
module ysyx_24090018_wbu #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 32
) (
    input logic                clk,
    input logic                rst,
    ysyx_24090018_wbu_if.slave wb
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    typedef enum logic {
        ARB_LAST_EXU = 1'b0,
        ARB_LAST_LSU = 1'b1
    } arb_state_e;

    arb_state_e                state_q, state_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic                      rf_wen_q, rf_wen_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
    logic                      sb_err_q, sb_err_d;

    logic                      last_lsu;
    logic                      hazard;
    logic                      issue_fire;
    logic                      exu_ready, lsu_ready;
    logic                      exu_acc, lsu_acc, acc;
    logic [REG_ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0]     acc_data;

    assign last_lsu = (state_q == ARB_LAST_LSU);

    // busy_q[0] is never set, so x0 sources/destinations never stall
    assign hazard = wb.issue_valid_i &
                    (busy_q[wb.issue_rs1_i] | busy_q[wb.issue_rs2_i] | busy_q[wb.issue_rd_i]);
    assign issue_fire = wb.issue_valid_i & ~hazard;

    assign exu_ready = ~wb.lsu_valid_i | last_lsu;
    assign lsu_ready = ~wb.exu_valid_i | ~last_lsu;
    assign exu_acc   = wb.exu_valid_i & exu_ready;
    assign lsu_acc   = wb.lsu_valid_i & lsu_ready;
    assign acc       = exu_acc | lsu_acc;
    assign acc_rd    = lsu_acc ? wb.lsu_rd_i   : wb.exu_rd_i;
    assign acc_data  = lsu_acc ? wb.lsu_data_i : wb.exu_data_i;

    always_comb begin
        state_d = state_q;
        if (wb.exu_valid_i && wb.lsu_valid_i) begin
            state_d = lsu_acc ? ARB_LAST_LSU : ARB_LAST_EXU;
        end
    end

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        sb_err_d   = sb_err_q;
        if (acc) begin
            rf_wen_d   = (acc_rd != '0);
            rf_waddr_d = acc_rd;
            rf_wdata_d = acc_data;
            if ((acc_rd != '0) && !busy_q[acc_rd]) begin
                sb_err_d = 1'b1;
            end
        end
    end

    // Clear is applied first so that a coinciding set wins
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_fire && (wb.issue_rd_i != '0)) begin
            busy_d[wb.issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_LAST_EXU;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign wb.hazard_o    = hazard;
    assign wb.exu_ready_o = exu_ready;
    assign wb.lsu_ready_o = lsu_ready;
    assign wb.rf_wen_o    = rf_wen_q;
    assign wb.rf_waddr_o  = rf_waddr_q;
    assign wb.rf_wdata_o  = rf_wdata_q;
    assign wb.busy_o      = busy_q;
    assign wb.sb_err_o    = sb_err_q;
endmodule

// File: tb/tb_ysyx_24090018_wbu.sv
// Self-checking bench for ysyx_24090018_wbu: a reference scoreboard queues the
// expected register-file writes at acceptance and compares them when they emerge.
module tb_ysyx_24090018_wbu;
    localparam int RW   = 4;
    localparam int DW   = 32;
    localparam int NREG = 1 << RW;

    typedef struct packed {
        logic          wen;
        logic [RW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24090018_wbu_if #(.REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

    ysyx_24090018_wbu #(.REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int            n_vec = 0;
    int            n_err = 0;
    wr_t           exp_q[$];
    logic [NREG-1:0] m_busy;
    logic          m_last_lsu, m_err, m_wen;
    logic [RW-1:0] m_waddr;
    logic          g_issued, g_exu_acc, g_lsu_acc;
    logic [7:0]    grant_log;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid_i = 1'b0;
        bus.issue_rd_i    = '0;
        bus.issue_rs1_i   = '0;
        bus.issue_rs2_i   = '0;
        bus.exu_valid_i   = 1'b0;
        bus.exu_rd_i      = '0;
        bus.exu_data_i    = '0;
        bus.lsu_valid_i   = 1'b0;
        bus.lsu_rd_i      = '0;
        bus.lsu_data_i    = '0;
    endtask

    task automatic set_issue(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = rd;
        bus.issue_rs1_i   = rs1;
        bus.issue_rs2_i   = rs2;
    endtask

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic cycle();
        logic hz, er, lr, ea, la;
        logic [NREG-1:0] nb;
        wr_t it;
        #1;
        hz = bus.issue_valid_i &
             (m_busy[bus.issue_rs1_i] | m_busy[bus.issue_rs2_i] | m_busy[bus.issue_rd_i]);
        er = !bus.lsu_valid_i || m_last_lsu;
        lr = !bus.exu_valid_i || !m_last_lsu;
        check("hazard", bus.hazard_o, hz);
        check("exu_ready", bus.exu_ready_o, er);
        check("lsu_ready", bus.lsu_ready_o, lr);
        ea = bus.exu_valid_i & er;
        la = bus.lsu_valid_i & lr;
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (bus.issue_valid_i && !hz && bus.issue_rd_i != 0) nb[bus.issue_rd_i] = 1'b1;
        if (ea || la) begin
            it.addr = la ? bus.lsu_rd_i : bus.exu_rd_i;
            it.data = la ? bus.lsu_data_i : bus.exu_data_i;
            it.wen  = (it.addr != 0);
            if (it.wen && !m_busy[it.addr]) m_err = 1'b1;
            exp_q.push_back(it);
        end
        if (bus.exu_valid_i && bus.lsu_valid_i) begin
            m_last_lsu = la;
            grant_log  = {grant_log[6:0], la};
        end
        g_issued  = bus.issue_valid_i & !hz;
        g_exu_acc = ea;
        g_lsu_acc = la;
        @(posedge clk);
        #1;
        m_busy = nb;
        if (ea || la) begin
            it = exp_q.pop_front();
            check("rf_wen", bus.rf_wen_o, it.wen);
            check("rf_waddr", bus.rf_waddr_o, it.addr);
            check("rf_wdata", bus.rf_wdata_o, it.data);
            m_wen   = it.wen;
            m_waddr = it.addr;
        end else begin
            check("rf_wen_idle", bus.rf_wen_o, 1'b0);
            m_wen = 1'b0;
        end
        check("busy", bus.busy_o, m_busy);
        check("sb_err", bus.sb_err_o, m_err);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_issue(4'd2, 4'd0, 4'd0);
        bus.exu_valid_i = 1'b1; bus.exu_rd_i = 4'd3; bus.exu_data_i = 32'hAAAA_0003;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 4'd4; bus.lsu_data_i = 32'hBBBB_0004;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_wen", bus.rf_wen_o, 1'b0);
        check("rst_rf_waddr", bus.rf_waddr_o, 0);
        check("rst_rf_wdata", bus.rf_wdata_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_sb_err", bus.sb_err_o, 1'b0);
        check("rst_exu_ready", bus.exu_ready_o, 1'b0);
        check("rst_lsu_ready", bus.lsu_ready_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        exp_q.delete();
        m_busy = '0; m_last_lsu = 1'b0; m_err = 1'b0; m_wen = 1'b0; m_waddr = '0;
        grant_log = '0;
    endtask

    initial begin
        int erd[2];
        int lrd[3];
        int ei, li, waited;
        erd = '{2, 4};
        lrd = '{1, 3, 5};
        rst = 1'b1;
        idle();
        do_reset();

        // RAW: x5 written by EXU, dependent instruction waits until it retires
        set_issue(4'd5, 4'd0, 4'd0);
        cycle();
        set_issue(4'd6, 4'd5, 4'd0);
        bus.exu_valid_i = 1'b1; bus.exu_rd_i = 4'd5; bus.exu_data_i = 32'hDEADBEEF;
        #1 check("raw_hazard", bus.hazard_o, 1'b1);
        cycle();
        bus.exu_valid_i = 1'b0;
        #1;
        check("raw_wen", bus.rf_wen_o, 1'b1);
        check("raw_waddr", bus.rf_waddr_o, 5);
        check("raw_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        check("raw_hold", bus.hazard_o, 1'b1);
        cycle();
        #1 check("raw_release", bus.hazard_o, 1'b0);
        cycle();
        idle();
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 4'd6; bus.lsu_data_i = 32'h0000_0066;
        cycle();
        idle();
        cycle();

        // Round-robin: issue x1..x5, then EXU and LSU compete
        for (int r = 1; r <= 5; r++) begin
            set_issue(r[RW-1:0], 4'd0, 4'd0);
            cycle();
        end
        idle();
        grant_log = '0;
        ei = 0; li = 0;
        for (int c = 0; c < 8 && (ei < 2 || li < 3); c++) begin
            bus.exu_valid_i = (ei < 2);
            bus.exu_rd_i    = RW'(erd[(ei < 2) ? ei : 0]);
            bus.exu_data_i  = 32'h1000 + erd[(ei < 2) ? ei : 0];
            bus.lsu_valid_i = (li < 3);
            bus.lsu_rd_i    = RW'(lrd[(li < 3) ? li : 0]);
            bus.lsu_data_i  = 32'h2000 + lrd[(li < 3) ? li : 0];
            cycle();
            if (g_exu_acc) ei++;
            if (g_lsu_acc) li++;
        end
        check("rr_grants", grant_log[3:0], 4'b1010);
        idle();
        cycle();
        check("rr_drained", bus.busy_o, 0);

        // x0 as destination: handshake completes without writing or marking busy
        set_issue(4'd0, 4'd0, 4'd0);
        cycle();
        idle();
        bus.exu_valid_i = 1'b1; bus.exu_rd_i = 4'd0; bus.exu_data_i = 32'h0000_0055;
        cycle();
        idle();
        check("x0_wen", bus.rf_wen_o, 1'b0);
        cycle();
        check("x0_busy", bus.busy_o, 0);
        check("x0_err", bus.sb_err_o, 1'b0);

        // WAW: a second write to x7 waits for the first to retire
        set_issue(4'd7, 4'd1, 4'd2);
        cycle();
        set_issue(4'd7, 4'd0, 4'd0);
        cycle();
        cycle();
        bus.exu_valid_i = 1'b1; bus.exu_rd_i = 4'd7; bus.exu_data_i = 32'h7777_0001;
        cycle();
        bus.exu_valid_i = 1'b0;
        waited = 0;
        g_issued = 1'b0;
        while (!g_issued && waited < 10) begin
            cycle();
            waited++;
        end
        check("waw_wait", waited, 2);
        idle();
        check("waw_rebusy", bus.busy_o[7], 1'b1);
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 4'd7; bus.lsu_data_i = 32'h7777_0002;
        cycle();
        idle();
        cycle();

        // Spurious write to non-busy x9: performed, and the error flag sticks
        bus.exu_valid_i = 1'b1; bus.exu_rd_i = 4'd9; bus.exu_data_i = 32'h9999_9999;
        cycle();
        idle();
        check("spur_wen", bus.rf_wen_o, 1'b1);
        check("spur_err", bus.sb_err_o, 1'b1);
        repeat (3) cycle();
        check("spur_sticky", bus.sb_err_o, 1'b1);
        do_reset();
        check("spur_cleared", bus.sb_err_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
